// File: rtl/cmd_sched_pkg.sv
// Shared definitions for the command scheduler.
//   state_t  : handshake FSM states
//   ADDR_MSB/ADDR_LSB/DATA_MSB : field positions within a 32-bit command word
//   NOP_ADDR : address byte marking a command that is discarded on capture
package cmd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  localparam int ADDR_MSB = 31;
  localparam int ADDR_LSB = 24;
  localparam int DATA_MSB = 23;

  localparam logic [7:0] NOP_ADDR = 8'h00;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO, DEPTH x 32 bits, first-word-fall-through read.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (pointers/count only)
//   push, wdata   : write request and word; ignored when full unless pop is also high
//   pop           : read request; ignored when empty
//   rdata         : word at the head of the queue
//   full, empty   : occupancy flags
//   count         : occupancy, 0..DEPTH
module cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  // A push into a full FIFO is accepted when a pop frees the head slot in the
  // same cycle; the head word is read before the write lands.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Command scheduler: captures completed command words from the byte-stream
// decoder, queues them, and issues them one at a time on the configuration
// bus with a 4-phase req/ack handshake.
// Optional feature macro: CMD_SCHEDULER_TIMEOUT_EN (per-phase handshake timeout).
// Ports:
//   iClk, iRst    : clock, asynchronous active-high reset
//   iCode         : command word, stable while iCode_Ready is high
//   iCode_Ready   : command-complete level, asynchronous to iClk
//   iClr          : pulse clearing oOverflow / oTimeout
//   iAck          : bus acknowledge
//   oReq          : bus request
//   oAddr, oData  : issued register address / write data (held after handshake)
//   oBusy         : FIFO non-empty or handshake in progress
//   oCount        : FIFO occupancy
//   oOverflow     : sticky, a command was dropped on a full FIFO
//   oTimeout      : sticky, a handshake phase timed out (0 when feature is off)
module cmd_scheduler
  import cmd_sched_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TO_CYCLES = 1000
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [31:0]              iCode,
  input  logic                     iCode_Ready,
  input  logic                     iClr,
  input  logic                     iAck,
  output logic                     oReq,
  output logic [7:0]               oAddr,
  output logic [23:0]              oData,
  output logic                     oBusy,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oOverflow,
  output logic                     oTimeout
);

  logic        s1, s2, s3;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [31:0] head;
  logic        ovf_evt;
  logic        to_evt;
  logic        req_nxt;
  state_t      state, state_nxt;

  // Input synchronisation: s1/s2 resolve metastability, s3 detects the edge
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= iCode_Ready;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // iCode has been stable long enough by the time the edge reaches s2
  assign push    = s2 && !s3 && (iCode[ADDR_MSB:ADDR_LSB] != NOP_ADDR);
  assign ovf_evt = push && full && !pop;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (iClk),
    .rst   (iRst),
    .push  (push),
    .pop   (pop),
    .wdata (iCode),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (oCount)
  );

  assign oBusy = !empty || (state != IDLE);

`ifdef CMD_SCHEDULER_TIMEOUT_EN
  localparam int TW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);
  logic [TW-1:0] to_cnt;

  // Restarts on every state change, so each handshake phase gets a full budget
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)                                   to_cnt <= '0;
    else if (state == IDLE || state_nxt != state) to_cnt <= '0;
    else                                        to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)         oTimeout <= 1'b0;
    else if (to_evt)  oTimeout <= 1'b1;
    else if (iClr)    oTimeout <= 1'b0;
  end
`else
  assign oTimeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    req_nxt   = oReq;
    pop       = 1'b0;
    to_evt    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          req_nxt   = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (iAck) begin
          req_nxt   = 1'b0;
          state_nxt = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!iAck) state_nxt = IDLE;
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
`ifdef CMD_SCHEDULER_TIMEOUT_EN
    // Abandon the command: no retry, the next queued one goes out from IDLE
    if (state != IDLE && to_cnt == TO_LAST) begin
      to_evt    = 1'b1;
      req_nxt   = 1'b0;
      state_nxt = IDLE;
    end
`endif
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= IDLE;
      oReq  <= 1'b0;
      oAddr <= '0;
      oData <= '0;
    end else begin
      state <= state_nxt;
      oReq  <= req_nxt;
      if (pop) begin
        oAddr <= head[ADDR_MSB:ADDR_LSB];
        oData <= head[DATA_MSB:0];
      end
    end
  end

  // A drop in the same cycle as iClr keeps the flag set
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)         oOverflow <= 1'b0;
    else if (ovf_evt) oOverflow <= 1'b1;
    else if (iClr)    oOverflow <= 1'b0;
  end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Scoreboard bench for cmd_scheduler: every command expected on the bus is
// queued when it is sent; a monitor compares each new oReq against the queue.
module tb_cmd_scheduler;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [31:0] iCode;
  logic        iCode_Ready;
  logic        iClr;
  logic        iAck;
  logic        oReq;
  logic [7:0]  oAddr;
  logic [23:0] oData;
  logic        oBusy;
  logic [2:0]  oCount;
  logic        oOverflow;
  logic        oTimeout;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  cmd_scheduler #(.DEPTH(4), .TO_CYCLES(16)) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iCode       (iCode),
    .iCode_Ready (iCode_Ready),
    .iClr        (iClr),
    .iAck        (iAck),
    .oReq        (oReq),
    .oAddr       (oAddr),
    .oData       (oData),
    .oBusy       (oBusy),
    .oCount      (oCount),
    .oOverflow   (oOverflow),
    .oTimeout    (oTimeout)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compares every newly raised request against the head of the scoreboard
  task automatic monitor();
    logic        prev = 1'b0;
    logic [31:0] w;
    forever begin
      @(negedge iClk);
      if (iRst) begin
        prev = 1'b0;
      end else begin
        if (oReq && !prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_req: got %0h, expected no request", {oAddr, oData});
          end else begin
            w = exp_q.pop_front();
            check("issue_word", {oAddr, oData}, w);
          end
        end
        prev = oReq;
      end
    end
  endtask

  // One command: iCode_Ready high for 4 edges, low for 3
  task automatic send_cmd(input logic [31:0] c, input bit issued);
    if (issued) exp_q.push_back(c);
    @(posedge iClk); #1;
    iCode       = c;
    iCode_Ready = 1'b1;
    repeat (4) @(posedge iClk);
    #1 iCode_Ready = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
  endtask

  // Completes one handshake, raising iAck two cycles after oReq is seen
  task automatic ack_one(input string tag);
    int n = 0;
    while (!oReq && n < 50) begin
      @(posedge iClk); #1;
      n++;
    end
    check({tag, "_req_seen"}, oReq, 1'b1);
    repeat (2) @(posedge iClk);
    #1 iAck = 1'b1;
    n = 0;
    while (oReq && n < 50) begin
      @(posedge iClk); #1;
      n++;
    end
    check({tag, "_req_drop"}, oReq, 1'b0);
    iAck = 1'b0;
    @(posedge iClk); #1;
  endtask

  task automatic pulse_clr();
    @(posedge iClk); #1 iClr = 1'b1;
    @(posedge iClk); #1 iClr = 1'b0;
  endtask

  initial begin
    int n;
    iRst        = 1'b1;
    iCode       = '0;
    iCode_Ready = 1'b0;
    iClr        = 1'b0;
    iAck        = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("rst_req", oReq, 1'b0);
    check("rst_addr_data", {oAddr, oData}, 32'h0);
    check("rst_busy", oBusy, 1'b0);
    check("rst_count", oCount, 3'd0);
    check("rst_flags", {oOverflow, oTimeout}, 2'b00);
    #1 iRst = 1'b0;

    // Single command and latency: Ready rises before edge 1
    exp_q.push_back(32'h0500ABCD);
    @(posedge iClk); #1;
    iCode       = 32'h0500ABCD;
    iCode_Ready = 1'b1;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("lat_edge3_req", oReq, 1'b0);
    check("lat_edge3_count", oCount, 3'd1);
    @(posedge iClk);
    @(negedge iClk);
    check("lat_edge4_req", oReq, 1'b1);
    check("lat_edge4_addr", oAddr, 8'h05);
    check("lat_edge4_data", oData, 24'h00ABCD);
    iCode_Ready = 1'b0;
    ack_one("single");
    @(negedge iClk);
    check("single_busy_after", oBusy, 1'b0);
    check("single_hold", {oAddr, oData}, 32'h0500ABCD);

    // NOP filter, with iAck toggling while idle
    send_cmd(32'h00123456, 1'b0);
    iAck = 1'b1;
    repeat (2) @(posedge iClk);
    #1 iAck = 1'b0;
    repeat (4) @(posedge iClk);
    @(negedge iClk);
    check("nop_count", oCount, 3'd0);
    check("nop_req", oReq, 1'b0);
    check("nop_busy", oBusy, 1'b0);

    // Overflow: 1 in flight, 4 queued, 6th dropped
    for (int i = 1; i <= 6; i++)
      send_cmd({8'h10 + 8'(i), 24'hA00000 + 24'(i)}, i <= 5);
    @(negedge iClk);
    check("ovf_count", oCount, 3'd4);
    check("ovf_flag", oOverflow, 1'b1);
    check("ovf_req", oReq, 1'b1);
    for (int i = 0; i < 5; i++) ack_one("ovf_drain");
    @(negedge iClk);
    check("ovf_drained", oCount, 3'd0);
    check("ovf_flag_kept", oOverflow, 1'b1);
    check("ovf_last_hold", {oAddr, oData}, 32'h15A00005);
    pulse_clr();
    @(negedge iClk);
    check("ovf_clr", oOverflow, 1'b0);

    // Full plus pop in the same cycle
    for (int i = 1; i <= 5; i++)
      send_cmd({8'h20 + 8'(i), 24'hB00000 + 24'(i)}, 1'b1);
    @(negedge iClk);
    check("fp_full_count", oCount, 3'd4);
    check("fp_full_flag", oOverflow, 1'b0);
    #1 iAck = 1'b1;
    n = 0;
    while (oReq && n < 20) begin
      @(posedge iClk); #1;
      n++;
    end
    check("fp_ack_accept", oReq, 1'b0);
    exp_q.push_back(32'h26B00006);
    iCode       = 32'h26B00006;
    iCode_Ready = 1'b1;
    @(posedge iClk); #1 iAck = 1'b0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    check("fp_count_same", oCount, 3'd4);
    check("fp_no_overflow", oOverflow, 1'b0);
    check("fp_issue_next", oReq, 1'b1);
    iCode_Ready = 1'b0;
    for (int i = 0; i < 5; i++) ack_one("fp_drain");
    @(negedge iClk);
    check("fp_drained", oCount, 3'd0);
    check("fp_last_hold", {oAddr, oData}, 32'h26B00006);

    // Handshake with iAck held low
    exp_q.push_back(32'h41C00001);
    @(posedge iClk); #1;
    iCode       = 32'h41C00001;
    iCode_Ready = 1'b1;
    n = 0;
    while (!oReq && n < 20) begin
      @(posedge iClk); #1;
      n++;
    end
    check("hold_req_up", oReq, 1'b1);
    iCode_Ready = 1'b0;
    n = 0;
    while (oReq && n < 40) begin
      @(posedge iClk); #1;
      n++;
    end
`ifdef CMD_SCHEDULER_TIMEOUT_EN
    check("to_cycles", n, 32'd16);
    check("to_flag", oTimeout, 1'b1);
    @(negedge iClk);
    check("to_idle", oBusy, 1'b0);
    pulse_clr();
    @(negedge iClk);
    check("to_clr", oTimeout, 1'b0);
    send_cmd(32'h42C00002, 1'b1);
    ack_one("to_next");
`else
    check("wait_req_held", oReq, 1'b1);
    check("wait_no_timeout", oTimeout, 1'b0);
    ack_one("wait_release");
`endif

    // Reset mid-handshake
    send_cmd(32'h31D00001, 1'b1);
    check("mid_req_up", oReq, 1'b1);
    send_cmd(32'h32D00002, 1'b0);
    check("mid_count", oCount, 3'd1);
    @(negedge iClk);
    #2 iRst = 1'b1;
    #1;
    check("mid_rst_req", oReq, 1'b0);
    check("mid_rst_count", oCount, 3'd0);
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b0;
    repeat (10) @(posedge iClk);
    @(negedge iClk);
    check("post_rst_req", oReq, 1'b0);
    check("post_rst_busy", oBusy, 1'b0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_scheduler.md
Name: cmd_scheduler

Overview:
- Sits between the byte-stream command decoder and the controller's configuration bus.
- Captures each completed 32-bit command word, queues it in a small FIFO, and issues queued commands one at a time over a 4-phase req/ack handshake.
- Top byte of the command word is the target register address; the low 24 bits are the write data.
- Crosses from the decoder's data-ready strobe domain into iClk.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- TO_CYCLES, 1000, iClk cycles allowed per handshake phase before timeout; only used with the optional feature.

Ports:
- iClk  in  1  system clock
- iRst  in  1  asynchronous, active-high reset
- iCode  in  32  command word from the decoder; stable while iCode_Ready is high
- iCode_Ready  in  1  command-complete level from the decoder; asynchronous to iClk
- iClr  in  1  single-cycle pulse; clears the sticky flags
- iAck  in  1  acknowledge from the configuration bus
- oReq  out  1  request to the configuration bus
- oAddr  out  8  register address (command bits 31:24)
- oData  out  24  write data (command bits 23:0)
- oBusy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE
- oCount  out  $clog2(DEPTH)+1  current FIFO occupancy
- oOverflow  out  1  sticky: a command was dropped because the FIFO was full
- oTimeout  out  1  sticky: a handshake phase timed out

Behaviour:
- Reset values: oReq=0, oAddr=0, oData=0, oBusy=0, oCount=0, oOverflow=0, oTimeout=0; FIFO pointers 0; FSM in IDLE.
- Reset takes effect asynchronously: oReq drops immediately, even mid-handshake.
- Input synchronisation:
  - iCode_Ready passes through a 3-flop chain s1, s2, s3.
  - Push condition is s2 & ~s3, giving exactly one push per rising edge of iCode_Ready.
  - iCode is sampled on the push cycle.
- NOP filter: a command with address byte 0x00 is discarded and is never written to the FIFO.
- Push when the FIFO is full with no pop in the same cycle: the new command is dropped, existing entries are unchanged, oOverflow is set.
- Push and pop in the same cycle when full: the push is accepted and oCount is unchanged.
- Read and write pointers wrap modulo DEPTH; oCount saturates neither at 0 nor at DEPTH, because both are unreachable by construction.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop and register oAddr/oData, set oReq=1, go to WAIT_ACK.
  - WAIT_ACK: when iAck=1, set oReq=0 and go to WAIT_REL.
  - WAIT_REL: when iAck=0, go to IDLE.
- oAddr/oData hold their last issued values after the handshake completes.
- Latency: if iCode_Ready rises before iClk edge 1, the push happens at edge 3 and oReq is high after edge 4, given IDLE and an empty FIFO.
- Back-to-back throughput: minimum 3 iClk per command. Next oReq rises the cycle after IDLE is re-entered.
- iAck already high on entry to WAIT_ACK: accepted on the next edge.
- iAck toggling while in IDLE: ignored.
- Sticky flags:
  - iClr clears both sticky flags.
  - A set event in the same cycle as iClr wins, and the flag stays 1.

Optional Feature:
- Macro: CMD_SCHEDULER_TIMEOUT_EN.
- When defined:
  - A counter is cleared on entering WAIT_ACK or WAIT_REL and increments each cycle spent in either state.
  - Reaching TO_CYCLES-1 sets oTimeout, forces oReq=0 and returns the FSM to IDLE.
  - The command is abandoned, not retried.
- When undefined: no counter is instantiated, oTimeout is tied 0, and the FSM waits indefinitely.

Decomposition:
- Shared package cmd_sched_pkg holds:
  - FSM state enum (IDLE, WAIT_ACK, WAIT_REL);
  - field constants ADDR_MSB=31, ADDR_LSB=24, DATA_MSB=23;
  - NOP_ADDR=8'h00.
- Sub-module cmd_fifo holds the synchronous FIFO: DEPTH x 32-bit storage, push, pop, full, empty, count.

Test Plan:
- Single command: iCode=32'h05_00ABCD, one iCode_Ready pulse, iAck returned 2 cycles after oReq -> oReq high 4 edges after the pulse with oAddr=8'h05, oData=24'h00ABCD; oBusy=0 after iAck falls.
- NOP filter: iCode=32'h00_123456 pulse -> no oReq, oCount stays 0.
- Overflow: hold iAck=0, send 6 distinct commands -> 1 in flight and 4 queued, 6th dropped, oOverflow=1, oCount=4; then ack all -> 5 issued in arrival order; iClr -> oOverflow=0.
- Full plus pop in the same cycle: FIFO full, push coincides with the IDLE pop -> push accepted, oCount stays 4, oOverflow stays 0.
- Reset mid-handshake: assert iRst while in WAIT_ACK -> oReq=0 immediately, oCount=0; after release no stale request.
- With CMD_SCHEDULER_TIMEOUT_EN and TO_CYCLES=16, iAck held 0 -> oReq drops after 16 cycles, oTimeout=1, next queued command issued.
